// File: rtl/mux4way_rr_arbiter.sv
// Four-input round-robin merge onto one registered valid/ready output channel.
// The output word is tagged with the index of the channel that supplied it.
module mux4way_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           in_valid,
  input  logic [4*WIDTH-1:0]   in_data,
  output logic [3:0]           in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_sel,
  input  logic                 out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;

  logic [1:0]       w_cand;
  logic [1:0]       w_winner;
  logic             w_found;
  logic             w_load_ok;
  logic             w_take;

  // Search from the pointer upward with wraparound; the first valid channel wins.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_cand   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_cand = r_ptr + k[1:0];
      if (!w_found && in_valid[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  // Reset gates the grant so nothing is offered while the block is held in reset.
  assign w_load_ok = (r_state == EMPTY) || out_ready;
  assign w_take    = w_found && w_load_ok && !reset;
  assign in_ready  = w_take ? (4'b0001 << w_winner) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd0;
    end else if (w_take) begin
      r_state <= FULL;
      r_data  <= in_data[w_winner*WIDTH +: WIDTH];
      r_sel   <= w_winner;
      r_ptr   <= w_winner + 2'd1;
    end else if (out_ready) begin
      r_state <= EMPTY;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule
